// File: rtl/ro_scan_if.sv
// ro_scan_if
// Result channel of the ring-oscillator scan counter.  The producer
// (master) presents an edge count, the channel it was measured on and a
// saturation flag, qualified by res_valid; the consumer (slave) accepts
// with res_ready.  A result is held stable until res_valid & res_ready.
//
// Signals:
//   res_data   CNT_W  edge count for one window
//   res_chan   SEL_W  channel index the count belongs to
//   res_sat    1      counter hit all-ones and dropped at least one edge
//   res_valid  1      result present
//   res_ready  1      consumer accepts the result this cycle
interface ro_scan_if #(
    parameter int CNT_W = 16,
    parameter int SEL_W = 11
);
    logic [CNT_W-1:0] res_data;
    logic [SEL_W-1:0] res_chan;
    logic             res_sat;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_data,
        output res_chan,
        output res_sat,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_chan,
        input  res_sat,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/ro_scan_counter.sv
// ro_scan_counter
// Selects one of NWAY ring-oscillator outputs, synchronises it into the clk
// domain and counts its rising edges over a programmable window.  One result
// per channel is returned on the ro_scan_if result channel.  Runs either
// measure a single channel or scan channels 0..NWAY-1, once or back-to-back.
// The counted RO must run below clk/2; faster oscillators alias.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         one-cycle pulse, begins a run when idle
//   continuous    restart runs back-to-back until cleared
//   single_mode   1 = measure chan_sel only, 0 = scan all channels
//   chan_sel      channel for single_mode
//   win_len       counting window in clk cycles (0 behaves as 1)
//   ro_in         raw RO outputs
//   ro_selected   raw RO currently routed by the select register
//   busy          a run is in progress
//   scan_done     one-cycle pulse after the last result of a run is accepted
//   sel_err       one-cycle pulse when a single-mode start names a bad channel
//   res           result channel (master side)
module ro_scan_counter #(
    parameter int NWAY       = 5,
    parameter int SEL_W      = 11,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 20,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             single_mode,
    input  logic [SEL_W-1:0] chan_sel,
    input  logic [WIN_W-1:0] win_len,
    input  logic [NWAY-1:0]  ro_in,
    output logic             ro_selected,
    output logic             busy,
    output logic             scan_done,
    output logic             sel_err,
    ro_scan_if.master        res
);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, OUTPUT} state_t;

    localparam logic [SEL_W-1:0] LAST_CHAN   = SEL_W'(NWAY - 1);
    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             single_q, single_d;
    logic             cont_q, cont_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             ro_mux;
    logic             ro_edge;
    logic             chan_bad;

    // Channel mux driven from the registered select, so the routed RO only
    // changes when the select register is loaded (always on entry to SETTLE).
    // Compared against each index rather than indexed, since SEL_W is wider
    // than the RO vector needs.
    always_comb begin
        ro_mux = 1'b0;
        for (int i = 0; i < NWAY; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ro_mux = ro_in[i];
            end
        end
    end

    assign ro_selected = ro_mux;

    // Two-flop synchroniser plus a delay flop; a rising edge of the RO is seen
    // as sync2 high while sync3 is still low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= ro_mux;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign ro_edge = sync2_q & ~sync3_q;

    // Widened compare so that NWAY == 2^SEL_W still rejects nothing.
    assign chan_bad = ({1'b0, chan_sel} >= (SEL_W + 1)'(NWAY));

    // Next-state logic.  A single down-counter times both the settle period
    // and the counting window; it is loaded with length-1 and the phase ends
    // on the cycle it reads zero.  The continuous flag is latched at start
    // but ANDed with the live input every cycle, so clearing it at any point
    // in a run suppresses the restart at the end of that run.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        single_d = single_q;
        cont_d   = cont_q & continuous;
        win_d    = win_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (single_mode && chan_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        sel_d    = single_mode ? chan_sel : '0;
                        single_d = single_mode;
                        cont_d   = continuous;
                        win_d    = (win_len == '0) ? WIN_W'(1) : win_len;
                        timer_d  = SETTLE_LOAD;
                    end
                end
            end

            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = COUNT;
                    timer_d = win_q - WIN_W'(1);
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end

            COUNT: begin
                if (ro_edge) begin
                    if (cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (timer_q == '0) begin
                    state_d = OUTPUT;
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end

            OUTPUT: begin
                if (res.res_ready) begin
                    if (!single_q && (sel_q != LAST_CHAN)) begin
                        state_d = SETTLE;
                        sel_d   = sel_q + SEL_W'(1);
                        timer_d = SETTLE_LOAD;
                    end else begin
                        done_d = 1'b1;
                        if (cont_q && continuous) begin
                            state_d = SETTLE;
                            sel_d   = single_q ? sel_q : '0;
                            timer_d = SETTLE_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.  The result fields are the counter and
    // select themselves: neither changes in OUTPUT, so they stay stable
    // under backpressure without a separate holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            single_q <= 1'b0;
            cont_q   <= 1'b0;
            win_q    <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            single_q <= single_d;
            cont_q   <= cont_d;
            win_q    <= win_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign res.res_valid = (state_q == OUTPUT);
    assign res.res_data  = cnt_q;
    assign res.res_chan  = sel_q;
    assign res.res_sat   = sat_q;
    assign busy          = (state_q != IDLE);
    assign scan_done     = done_q;
    assign sel_err       = err_q;

endmodule

// File: tb/tb_ro_scan_counter.sv
// tb_ro_scan_counter
// Scoreboard bench for ro_scan_counter.  Each RO input k is a square wave of
// period 2*(k+2) clk cycles.  The stimulus side pushes one expected result
// per window it asks for; the monitor pops and compares whenever a result is
// presented.  An expected count is derived from the window length alone: any
// W consecutive cycles of a period-P square wave hold floor(W/P) or
// ceil(W/P) rising edges.
module tb_ro_scan_counter;

    localparam int NWAY       = 5;
    localparam int SEL_W      = 11;
    localparam int CNT_W      = 6;
    localparam int WIN_W      = 20;
    localparam int SETTLE_CYC = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             continuous;
    logic             single_mode;
    logic [SEL_W-1:0] chan_sel;
    logic [WIN_W-1:0] win_len;
    logic [NWAY-1:0]  ro_in;
    logic             ro_selected;
    logic             busy;
    logic             scan_done;
    logic             sel_err;

    ro_scan_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) resIf ();

    ro_scan_counter #(
        .NWAY(NWAY), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .single_mode(single_mode), .chan_sel(chan_sel), .win_len(win_len),
        .ro_in(ro_in), .ro_selected(ro_selected), .busy(busy),
        .scan_done(scan_done), .sel_err(sel_err), .res(resIf)
    );

    typedef struct {
        int chan;
        int win;
        int lo;
        int hi;
        bit last;
        bit endIdle;
        int startCyc;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acceptCount = 0;
    int   stallUntil = -1;
    bit   readyRandom = 1'b0;

    always #5 clk = ~clk;

    // Cycle index: during cycle n (after posedge n) cyc reads n.
    always @(posedge clk) cyc <= cyc + 1;

    // RO waveforms and consumer ready, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NWAY; k++) begin
            ro_in[k] = ((cyc / (k + 2)) % 2) == 1;
        end
        if (cyc < stallUntil)   resIf.res_ready = 1'b0;
        else if (readyRandom)   resIf.res_ready = ($urandom_range(0, 3) != 0);
        else                    resIf.res_ready = 1'b1;
    end

    task automatic checkOutput(input string name, input longint act,
                               input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            if (lo == hi)
                $display("[TB] FAIL %s: got %0d, expected %0d", name, act, lo);
            else
                $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: compares each presented result against the head of the
    // scoreboard, checks it stays put under backpressure, and checks the
    // scan_done / busy behaviour in the cycle after each accept.
    bit               inOut = 1'b0;
    bit               pendDone = 1'b0;
    bit               pendIdle = 1'b0;
    int               lastHs = 0;
    int               firstCyc = 0;
    logic [CNT_W-1:0] snapData;
    logic [SEL_W-1:0] snapChan;
    logic             snapSat;
    exp_t             cur;

    always @(negedge clk) begin
        if (rst) begin
            inOut    = 1'b0;
            pendDone = 1'b0;
            pendIdle = 1'b0;
        end else begin
            if (pendDone) begin
                checkOutput("scan_done pulse", scan_done, 1, 1);
                checkOutput("busy after run end", busy, pendIdle ? 0 : 1, pendIdle ? 0 : 1);
                pendDone = 1'b0;
            end else begin
                checkOutput("scan_done quiet", scan_done, 0, 0);
            end

            if (resIf.res_valid) begin
                if (!inOut) begin
                    inOut    = 1'b1;
                    firstCyc = cyc;
                    snapData = resIf.res_data;
                    snapChan = resIf.res_chan;
                    snapSat  = resIf.res_sat;
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected result: got chan %0d data %0d, expected none",
                                 resIf.res_chan, resIf.res_data);
                    end else begin
                        cur = sbQ[0];
                        checkOutput("result latency", cyc,
                                    (cur.startCyc >= 0 ? cur.startCyc : lastHs) + 1 + SETTLE_CYC + cur.win,
                                    (cur.startCyc >= 0 ? cur.startCyc : lastHs) + 1 + SETTLE_CYC + cur.win);
                        checkOutput("res_chan", resIf.res_chan, cur.chan, cur.chan);
                        if (cur.lo > CNT_MAX) begin
                            checkOutput("res_data saturated", resIf.res_data, CNT_MAX, CNT_MAX);
                            checkOutput("res_sat set", resIf.res_sat, 1, 1);
                        end else if (cur.hi <= CNT_MAX) begin
                            checkOutput("res_data count", resIf.res_data, cur.lo, cur.hi);
                            checkOutput("res_sat clear", resIf.res_sat, 0, 0);
                        end else begin
                            checkOutput("res_data at limit", resIf.res_data, CNT_MAX, CNT_MAX);
                        end
                    end
                end
                if (resIf.res_ready) begin
                    if (cyc != firstCyc) begin
                        checkOutput("res_data stable", resIf.res_data, snapData, snapData);
                        checkOutput("res_chan stable", resIf.res_chan, snapChan, snapChan);
                        checkOutput("res_sat stable", resIf.res_sat, snapSat, snapSat);
                    end
                    if (sbQ.size() > 0) begin
                        cur      = sbQ.pop_front();
                        pendDone = cur.last;
                        pendIdle = cur.endIdle;
                    end
                    lastHs = cyc;
                    inOut  = 1'b0;
                    acceptCount++;
                end
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) checkOutput("wait for idle", busy, 0, 0);
    endtask

    // Issues one run (possibly several back-to-back in continuous mode) and
    // queues the expected results; the run parameters are scrambled and a
    // stray start is pulsed mid-run, none of which may affect the run.
    task automatic applyStimulus(input bit single, input int chan, input int win,
                                 input bit cont, input int runs, input int stall);
        int   weff;
        int   perRun;
        int   base;
        int   n;
        int   p;
        int   limit;
        exp_t e;
        weff   = (win == 0) ? 1 : win;
        perRun = single ? 1 : NWAY;
        limit  = runs * perRun * (weff + SETTLE_CYC + 80) + stall + 100;
        waitIdle();
        @(posedge clk);
        #1;
        base = acceptCount;
        for (int r = 0; r < runs; r++) begin
            for (int c = 0; c < perRun; c++) begin
                e.chan     = single ? chan : c;
                p          = 2 * (e.chan + 2);
                e.win      = weff;
                e.lo       = weff / p;
                e.hi       = (weff + p - 1) / p;
                e.last     = (c == perRun - 1);
                e.endIdle  = e.last && (r == runs - 1);
                e.startCyc = (r == 0 && c == 0) ? cyc : -1;
                sbQ.push_back(e);
            end
        end
        if (stall > 0) stallUntil = cyc + stall;
        start       = 1'b1;
        single_mode = single;
        chan_sel    = SEL_W'(chan);
        win_len     = WIN_W'(win);
        continuous  = cont;
        @(posedge clk);
        #1;
        start       = 1'b0;
        single_mode = 1'($urandom_range(0, 1));
        chan_sel    = SEL_W'($urandom_range(0, 7));
        win_len     = WIN_W'($urandom_range(0, 50));
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (cont) begin
            n = 0;
            while ((acceptCount - base) < (runs - 1) * perRun && n < limit) begin
                @(posedge clk);
                #1;
                n++;
            end
            continuous = 1'b0;
        end
        n = 0;
        while (sbQ.size() != 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("results outstanding", sbQ.size(), 0, 0);
            sbQ.delete();
        end
        continuous = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Single-mode start with an out-of-range channel: error pulse, no run.
    task automatic selErrTest(input int chan);
        waitIdle();
        @(posedge clk);
        #1;
        start       = 1'b1;
        single_mode = 1'b1;
        chan_sel    = SEL_W'(chan);
        win_len     = WIN_W'(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("sel_err pulse", sel_err, 1, 1);
        checkOutput("busy after bad select", busy, 0, 0);
        @(negedge clk);
        checkOutput("sel_err one cycle", sel_err, 0, 0);
        checkOutput("busy stays low", busy, 0, 0);
    endtask

    // Reset in the middle of a counting window: outputs clear at once and no
    // result ever appears (the monitor reports any result it is not expecting).
    task automatic resetMidRun();
        waitIdle();
        @(posedge clk);
        #1;
        start       = 1'b1;
        single_mode = 1'b0;
        win_len     = WIN_W'(200);
        continuous  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (SETTLE_CYC + 40) @(posedge clk);
        #2;
        checkOutput("busy before reset", busy, 1, 1);
        rst = 1'b1;
        #1;
        checkOutput("reset res_valid", resIf.res_valid, 0, 0);
        checkOutput("reset res_data", resIf.res_data, 0, 0);
        checkOutput("reset res_chan", resIf.res_chan, 0, 0);
        checkOutput("reset res_sat", resIf.res_sat, 0, 0);
        checkOutput("reset busy", busy, 0, 0);
        checkOutput("reset scan_done", scan_done, 0, 0);
        checkOutput("reset sel_err", sel_err, 0, 0);
        sbQ.delete();
        continuous = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        checkOutput("idle after aborted run", busy, 0, 0);
    endtask

    bit s;
    bit c;
    int ch;
    int w;
    int runs;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        single_mode = 1'b0;
        chan_sel    = '0;
        win_len     = '0;
        #2;
        checkOutput("init res_valid", resIf.res_valid, 0, 0);
        checkOutput("init res_data", resIf.res_data, 0, 0);
        checkOutput("init busy", busy, 0, 0);
        checkOutput("init scan_done", scan_done, 0, 0);
        checkOutput("init sel_err", sel_err, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] single channel 2, window 100");
        applyStimulus(1'b1, 2, 100, 1'b0, 1, 0);
        $display("[TB] full scan, window 120");
        applyStimulus(1'b0, 0, 120, 1'b0, 1, 0);
        $display("[TB] scan under a 50-cycle stall");
        applyStimulus(1'b0, 0, 20, 1'b0, 1, 50);
        $display("[TB] saturation boundaries");
        applyStimulus(1'b1, 0, 300, 1'b0, 1, 0);
        applyStimulus(1'b1, 0, 20, 1'b0, 1, 0);
        applyStimulus(1'b1, 0, 252, 1'b0, 1, 0);
        applyStimulus(1'b1, 0, 256, 1'b0, 1, 0);
        $display("[TB] bad channel select");
        selErrTest(7);
        selErrTest(2047);
        $display("[TB] continuous runs and zero-length window");
        applyStimulus(1'b0, 0, 10, 1'b1, 3, 0);
        applyStimulus(1'b1, 3, 0, 1'b1, 2, 0);
        applyStimulus(1'b1, 4, 0, 1'b0, 1, 0);
        $display("[TB] reset mid-count");
        resetMidRun();

        $display("[TB] randomized runs with random backpressure");
        readyRandom = 1'b1;
        for (int i = 0; i < 14; i++) begin
            s    = 1'($urandom_range(0, 1));
            ch   = $urandom_range(0, NWAY - 1);
            w    = s ? $urandom_range(0, 260) : $urandom_range(0, 120);
            c    = ($urandom_range(0, 3) == 0);
            runs = c ? $urandom_range(1, 2) : 1;
            applyStimulus(s, ch, w, c, runs, 0);
            if (i % 5 == 2) selErrTest($urandom_range(NWAY, 2047));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
